// File: rtl/l8_pkg.sv
// Shared definitions for the layer-8 output address generator: default
// geometry, FSM state encoding and the z-counter wrap check.
package l8_pkg;

  localparam int IMG_W_L8  = 14;
  localparam int IMG_H_L8  = 14;
  localparam int N_FILT_L8 = 32;
  localparam int ADDR_W_L8 = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The z counter only ever wraps out of the values 1 or 3.
  function automatic logic z_wrap_ok(input logic [1:0] z_v);
    return (z_v == 2'd1) || (z_v == 2'd3);
  endfunction

endpackage

// File: rtl/pos_count_l8.sv
// Cascaded col -> row -> filt wrap counter; tc flags the final position.
module pos_count_l8
  import l8_pkg::*;
#(
  parameter int IMG_W  = IMG_W_L8,
  parameter int IMG_H  = IMG_H_L8,
  parameter int N_FILT = N_FILT_L8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  output logic [$clog2(IMG_W)-1:0]  col,
  output logic [$clog2(IMG_H)-1:0]  row,
  output logic [$clog2(N_FILT)-1:0] filt,
  output logic                      tc
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(N_FILT);

  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(N_FILT - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [FW-1:0] filt_q, filt_d;

  // Position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= {CW{1'b0}};
      row_q  <= {RW{1'b0}};
      filt_q <= {FW{1'b0}};
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      filt_q <= filt_d;
    end
  end

  // Next position: each stage only moves when every faster stage wraps
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    filt_d = filt_q;
    if (clr) begin
      col_d  = {CW{1'b0}};
      row_d  = {RW{1'b0}};
      filt_d = {FW{1'b0}};
    end else if (en) begin
      if (col_q == COL_MAX) begin
        col_d = {CW{1'b0}};
        if (row_q == ROW_MAX) begin
          row_d = {RW{1'b0}};
          if (filt_q == FILT_MAX) begin
            filt_d = {FW{1'b0}};
          end else begin
            filt_d = filt_q + FW'(1'b1);
          end
        end else begin
          row_d = row_q + RW'(1'b1);
        end
      end else begin
        col_d = col_q + CW'(1'b1);
      end
    end else begin
      col_d  = col_q;
      row_d  = row_q;
      filt_d = filt_q;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign filt = filt_q;
  assign tc   = (col_q == COL_MAX) && (row_q == ROW_MAX) && (filt_q == FILT_MAX);

endmodule

// File: rtl/out_addr_gen_l8.sv
// Turns z-loop pixel-complete pulses into output-buffer writes with linear
// filter-major addresses, one pending slot of back-pressure absorption.
module out_addr_gen_l8
  import l8_pkg::*;
#(
  parameter int IMG_W  = IMG_W_L8,
  parameter int IMG_H  = IMG_H_L8,
  parameter int N_FILT = N_FILT_L8,
  parameter int ADDR_W = ADDR_W_L8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                z,
  input  logic                      z_zero,
  input  logic                      wr_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [$clog2(IMG_W)-1:0]  col,
  output logic [$clog2(IMG_H)-1:0]  row,
  output logic [$clog2(N_FILT)-1:0] filt,
  output logic                      busy,
  output logic                      done,
  output logic                      ovf_err,
  output logic                      proto_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H * N_FILT - 1);

  state_e              state_q, state_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                proto_q, proto_d;
  logic                accept_s, capture_s, clr_s, tc_s, run_s;

  pos_count_l8 #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .N_FILT (N_FILT)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .en   (accept_s),
    .col  (col),
    .row  (row),
    .filt (filt),
    .tc   (tc_s)
  );

  // State, pending slot, address and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      proto_q   <= proto_d;
    end
  end

  // Next-state, pending slot, address and sticky error logic
  always_comb begin
    state_d   = state_q;
    clr_s     = 1'b0;
    run_s     = (state_q == RUN);
    accept_s  = pend_q && wr_ready;
    // A freed slot on the same edge lets a new pulse in without overflow.
    capture_s = run_s && z_zero && (!pend_q || wr_ready);
    ovf_d     = ovf_q || (run_s && z_zero && pend_q && !wr_ready);
    proto_d   = proto_q || (run_s && z_zero && !z_wrap_ok(z));

    if (accept_s) begin
      wr_addr_d = (wr_addr_q == LAST_ADDR) ? {ADDR_W{1'b0}} : wr_addr_q + ADDR_W'(1'b1);
    end else begin
      wr_addr_d = wr_addr_q;
    end

    if (capture_s) begin
      pend_d = 1'b1;
    end else if (accept_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clr_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The captured pixel sits at wr_addr_d; once that is the last one, stop taking pulses.
        if (capture_s && (wr_addr_d == LAST_ADDR)) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (accept_s && tc_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          clr_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clr_s) begin
      wr_addr_d = {ADDR_W{1'b0}};
      pend_d    = 1'b0;
    end else begin
      wr_addr_d = wr_addr_d;
      pend_d    = pend_d;
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  assign wr_en     = pend_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf_err   = ovf_q;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_out_addr_gen_l8.sv
// Scoreboard bench: a 2x2x2 instance for the directed scenarios and a
// default-geometry instance for the full 14x14x32 pass.
module tb_out_addr_gen_l8;

  typedef struct {
    int addr;
    int col;
    int row;
    int filt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  // ---------------- small instance (2x2x2) ----------------
  logic       rst_s = 1'b1, start_s = 1'b0, z_zero_s = 1'b0, wr_ready_s = 1'b1;
  logic [1:0] z_s = 2'd3;
  logic       wr_en_s, busy_s, done_s, ovf_s, proto_s;
  logic [2:0] wr_addr_s;
  logic [0:0] col_s, row_s, filt_s;

  out_addr_gen_l8 #(.IMG_W(2), .IMG_H(2), .N_FILT(2), .ADDR_W(3)) dut_s (
    .clk(clk), .rst(rst_s), .start(start_s), .z(z_s), .z_zero(z_zero_s),
    .wr_ready(wr_ready_s), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .col(col_s),
    .row(row_s), .filt(filt_s), .busy(busy_s), .done(done_s),
    .ovf_err(ovf_s), .proto_err(proto_s)
  );

  // ---------------- default instance (14x14x32) ----------------
  logic        rst_l = 1'b1, start_l = 1'b0, z_zero_l = 1'b0, wr_ready_l = 1'b1;
  logic [1:0]  z_l = 2'd1;
  logic        wr_en_l, busy_l, done_l, ovf_l, proto_l;
  logic [12:0] wr_addr_l;
  logic [3:0]  col_l, row_l;
  logic [4:0]  filt_l;

  out_addr_gen_l8 dut_l (
    .clk(clk), .rst(rst_l), .start(start_l), .z(z_l), .z_zero(z_zero_l),
    .wr_ready(wr_ready_l), .wr_en(wr_en_l), .wr_addr(wr_addr_l), .col(col_l),
    .row(row_l), .filt(filt_l), .busy(busy_l), .done(done_l),
    .ovf_err(ovf_l), .proto_err(proto_l)
  );

  exp_t q_s[$];
  exp_t q_l[$];
  int   wr_cnt_s = 0, dn_cnt_s = 0, wr_cnt_l = 0, dn_cnt_l = 0, last_addr_l = -1;
  bit   done_exp_s = 1'b0, done_exp_l = 1'b0;

  function automatic void push_s(input int i);
    exp_t e;
    e.addr = i; e.col = i % 2; e.row = (i / 2) % 2; e.filt = i / 4;
    q_s.push_back(e);
  endfunction

  // Monitor for the small instance: pops on every accepted write
  always @(negedge clk) begin
    exp_t e;
    bit   fin;
    fin = 1'b0;
    if (wr_en_s && wr_ready_s) begin
      wr_cnt_s++;
      if (q_s.size() == 0) begin
        chk("s_unexpected_write", 1, 0);
      end else begin
        e = q_s.pop_front();
        chk("s_wr_addr", int'(wr_addr_s), e.addr);
        chk("s_col", int'(col_s), e.col);
        chk("s_row", int'(row_s), e.row);
        chk("s_filt", int'(filt_s), e.filt);
        fin = (e.addr == 7);
      end
    end else if (wr_en_s && q_s.size() > 0) begin
      chk("s_stall_addr", int'(wr_addr_s), q_s[0].addr);
    end
    if (done_s || done_exp_s) chk("s_done_timing", int'(done_s), int'(done_exp_s));
    if (done_s) dn_cnt_s++;
    done_exp_s = fin;
  end

  // Monitor for the default instance
  always @(negedge clk) begin
    exp_t e;
    bit   fin;
    fin = 1'b0;
    if (wr_en_l && wr_ready_l) begin
      wr_cnt_l++;
      last_addr_l = int'(wr_addr_l);
      if (q_l.size() == 0) begin
        chk("l_unexpected_write", 1, 0);
      end else begin
        e = q_l.pop_front();
        if (wr_addr_l != 13'(e.addr)) chk("l_wr_addr", int'(wr_addr_l), e.addr);
        if ({filt_l, row_l, col_l} != {5'(e.filt), 4'(e.row), 4'(e.col)}) begin
          chk("l_pos", {filt_l, row_l, col_l}, {e.filt, e.row, e.col});
        end
        fin = (e.addr == 6271);
      end
    end
    if (done_l || done_exp_l) chk("l_done_timing", int'(done_l), int'(done_exp_l));
    if (done_l) dn_cnt_l++;
    done_exp_l = fin;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_s();
    rst_s = 1'b1; start_s = 1'b0; z_zero_s = 1'b0; wr_ready_s = 1'b1; z_s = 2'd3;
    cyc(2);
    rst_s = 1'b0;
  endtask

  task automatic start_pulse_s();
    start_s = 1'b1;
    cyc(1);
    start_s = 1'b0;
  endtask

  task automatic pulse_s(input logic [1:0] zv, input int gap);
    z_zero_s = 1'b1; z_s = zv;
    cyc(1);
    z_zero_s = 1'b0;
    if (gap > 0) cyc(gap);
  endtask

  int wb, db;

  initial begin
    cyc(2);
    rst_l = 1'b0;

    // 1: basic pass, pulses three cycles apart
    reset_s();
    chk("rst_wr_en", int'(wr_en_s), 0);
    chk("rst_wr_addr", int'(wr_addr_s), 0);
    chk("rst_pos", int'({filt_s, row_s, col_s}), 0);
    chk("rst_busy", int'(busy_s), 0);
    chk("rst_flags", int'({done_s, ovf_s, proto_s}), 0);
    wb = wr_cnt_s; db = dn_cnt_s;
    pulse_s(2'd3, 2);                       // in IDLE: ignored
    start_pulse_s();
    chk("t1_busy", int'(busy_s), 1);
    for (int i = 0; i < 8; i++) begin
      push_s(i);
      pulse_s(2'd3, 2);
      if (i == 3) start_pulse_s();          // start while busy: ignored
    end
    cyc(4);
    chk("t1_writes", wr_cnt_s - wb, 8);
    chk("t1_done_cnt", dn_cnt_s - db, 1);
    chk("t1_busy_end", int'(busy_s), 0);
    chk("t1_flags", int'({ovf_s, proto_s}), 0);
    chk("t1_drained", q_s.size(), 0);

    // 2: four-cycle stall after the third pulse, fourth pulse overflows
    reset_s();
    wb = wr_cnt_s; db = dn_cnt_s;
    start_pulse_s();
    for (int i = 0; i < 3; i++) begin
      push_s(i);
      pulse_s(2'd3, (i == 2) ? 0 : 2);
    end
    wr_ready_s = 1'b0;
    cyc(1);
    chk("t2_stall_wr_en", int'(wr_en_s), 1);
    pulse_s(2'd3, 0);                       // dropped
    cyc(2);
    chk("t2_ovf", int'(ovf_s), 1);
    chk("t2_stall_addr_hold", int'(wr_addr_s), 2);
    wr_ready_s = 1'b1;
    cyc(2);
    for (int i = 3; i < 7; i++) begin
      push_s(i);
      pulse_s(2'd3, 2);
    end
    cyc(4);
    chk("t2_writes", wr_cnt_s - wb, 7);
    chk("t2_done_cnt", dn_cnt_s - db, 0);
    chk("t2_still_busy", int'(busy_s), 1);
    chk("t2_ovf_sticky", int'(ovf_s), 1);
    chk("t2_drained", q_s.size(), 0);

    // 3: pulse every cycle, write accepted on the same edge
    reset_s();
    wb = wr_cnt_s; db = dn_cnt_s;
    start_pulse_s();
    for (int i = 0; i < 8; i++) push_s(i);
    z_zero_s = 1'b1; z_s = 2'd1;
    cyc(8);
    z_zero_s = 1'b0;
    cyc(4);
    chk("t3_writes", wr_cnt_s - wb, 8);
    chk("t3_done_cnt", dn_cnt_s - db, 1);
    chk("t3_ovf", int'(ovf_s), 0);
    chk("t3_drained", q_s.size(), 0);

    // 4: protocol error with z=2, write still happens
    reset_s();
    start_pulse_s();
    push_s(0);
    pulse_s(2'd2, 3);
    chk("t4_proto", int'(proto_s), 1);
    push_s(1);
    pulse_s(2'd1, 3);
    chk("t4_proto_sticky", int'(proto_s), 1);
    chk("t4_drained", q_s.size(), 0);
    reset_s();
    chk("t4_proto_cleared", int'(proto_s), 0);

    // 5: reset after the fifth write, then restart from 0
    start_pulse_s();
    for (int i = 0; i < 5; i++) begin
      push_s(i);
      pulse_s(2'd3, 2);
    end
    chk("t5_pre_addr", int'(wr_addr_s), 5);
    rst_s = 1'b1;
    cyc(1);
    rst_s = 1'b0;
    chk("t5_wr_en", int'(wr_en_s), 0);
    chk("t5_wr_addr", int'(wr_addr_s), 0);
    chk("t5_pos", int'({filt_s, row_s, col_s}), 0);
    chk("t5_status", int'({busy_s, done_s, ovf_s, proto_s}), 0);
    start_pulse_s();
    push_s(0);
    pulse_s(2'd3, 3);
    chk("t5_restart_drained", q_s.size(), 0);

    // 6: full default geometry
    wb = wr_cnt_l; db = dn_cnt_l;
    start_l = 1'b1;
    cyc(1);
    start_l = 1'b0;
    for (int i = 0; i < 6272; i++) begin
      exp_t e;
      e.addr = i; e.col = i % 14; e.row = (i / 14) % 14; e.filt = i / 196;
      q_l.push_back(e);
    end
    z_zero_l = 1'b1;
    cyc(6272);
    z_zero_l = 1'b0;
    cyc(5);
    chk("t6_writes", wr_cnt_l - wb, 6272);
    chk("t6_last_addr", last_addr_l, 6271);
    chk("t6_done_cnt", dn_cnt_l - db, 1);
    chk("t6_flags", int'({busy_l, ovf_l, proto_l}), 0);
    chk("t6_drained", q_l.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
